store_narrower: RTL and testbench
=================================

Name: store_narrower

Overview:
- Opposite direction of the load-side extender: takes a 64-bit register value plus an access size (byte/half/word/double) and serializes its low bytes onto a narrow LENGTH-bit store bus, least-significant chunk first.
- Flags whether the truncation is lossless, i.e. whether the load-side extender, given the same size and sign, reproduces the original 64-bit value.
- Sits between the MEM-stage store path and the narrow data-memory write port.
- Uses valid/ready handshakes on both sides.

Parameters:
- LENGTH, 16, output chunk width in bits; legal values 8, 16, 32 (must divide 64).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word.
- in_data  input  64  register value to store.
- in_size  input  2  access size: 00 = 8 bits, 01 = 16, 10 = 32, 11 = 64.
- in_sign  input  1  1 = the value is to be treated as signed for the fits check and for padding.
- out_valid  output  1  out_data holds a valid chunk.
- out_ready  input  1  downstream accepts the chunk.
- out_data  output  LENGTH  current chunk.
- out_last  output  1  current chunk is the final chunk of the word.
- out_fits  output  1  truncation is lossless; valid while out_valid.

Behaviour:
- Clock/reset: one clock domain. Reset is asynchronous and active-low: while reset=0 the FSM is forced to IDLE, and out_valid=0, out_last=0, out_fits=0, out_data=0, in_ready=0. Once reset=1, in_ready=1 from the next edge onward.
- FSM states: IDLE and SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - On the edge where in_valid=1:
    - Latch in_data, in_size and in_sign.
    - Compute B = 8<<in_size bits and N = max(1, B/LENGTH) chunks.
    - Compute fits and register it to out_fits.
    - Set the chunk index to 0 and go to SEND.
- SEND:
  - in_ready=0; in_valid is ignored and the latched word is never disturbed.
  - out_valid=1; out_data = latched bits [idx*LENGTH +: LENGTH].
  - out_last = (idx == N-1).
  - On an edge with out_ready=1: if out_last, go to IDLE; otherwise idx increments.
  - With out_ready=0: out_data, out_last and out_fits hold stable.
- Throughput: N chunk cycles plus one IDLE cycle per word. There is no back-to-back acceptance in the last SEND cycle.
- Padding when B < LENGTH: the single chunk carries the B data bits in its low part. Its upper LENGTH-B bits are in_data[B-1] if in_sign=1, and 0 otherwise. This matches the extender's reconstruction.
- fits:
  - B = 64: always 1.
  - in_sign=1: 1 iff in_data[63:B-1] are all equal.
  - in_sign=0: 1 iff in_data[63:B] are all zero.
  - out_fits is informational only; the data is always sent truncated.
- Reset mid-SEND: the word is dropped immediately, with no partial completion. After release, the next word starts at chunk 0.
- Latency: the first chunk is valid on the cycle after acceptance.

Test Plan (LENGTH=16):
1. size=11, data=0x1122334455667788, out_ready=1 -> chunks 0x7788, 0x5566, 0x3344, 0x1122 on 4 consecutive cycles; out_last only on 0x1122; out_fits=1; in_ready=1 the following cycle.
2. size=00, sign=1, data=0xFFFFFFFFFFFFFFFD (-3) -> one chunk 0xFFFD, out_last=1, out_fits=1. Same with sign=0 -> chunk 0x00FD, out_fits=0.
3. size=00, data=0x00000000000000F4: sign=0 -> 0x00F4, fits=1; sign=1 -> 0xFFF4, fits=0 (244 is not representable as a signed byte).
4. size=10, sign=0, data=0x00000000DEADBEEF, out_ready low for 3 cycles -> 0xBEEF held stable for all 3 cycles, then 0xDEAD with out_last, fits=1. Repeat with sign=1 -> fits=0.
5. size=11, reset pulsed low after the first chunk is accepted -> out_valid=0 asynchronously. After release, a new word 0x000000000000000A emits 0x000A first.
6. in_valid held high with changing data throughout SEND -> in_ready=0 and the emitted chunks are unaffected. The second word is accepted only in IDLE.

Source files
------------

// File: rtl/store_narrower.sv
// Serialises the low bytes of a 64-bit store value onto a narrow bus, LSB chunk first.
// It also flags whether the load-side extender would rebuild the original value.
module store_narrower #(
    parameter int LENGTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_data,
    input  logic [1:0]        in_size,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LENGTH-1:0] out_data,
    output logic              out_last,
    output logic              out_fits
);

    localparam int NCHUNK = 64 / LENGTH;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       data_q, data_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   last_q, last_d;
    logic              fits_q, fits_d;
    logic              rdy_q, rdy_d;

    logic              accept;
    logic              is_last;
    logic [63:0]       ext;
    logic [LENGTH-1:0] chunk [NCHUNK];
    int                nbits;
    int                nlast;

    assign accept  = (state_q == IDLE) && rdy_q && in_valid;
    assign is_last = (idx_q == last_q);

    // Truncate then re-extend: this is exactly what the load side rebuilds,
    // so it doubles as padding for sub-chunk sizes and as the fits reference.
    always_comb begin
        ext = in_data;
        case (in_size)
            2'b00:   ext = {{56{in_sign & in_data[7]}},  in_data[7:0]};
            2'b01:   ext = {{48{in_sign & in_data[15]}}, in_data[15:0]};
            2'b10:   ext = {{32{in_sign & in_data[31]}}, in_data[31:0]};
            default: ext = in_data;
        endcase
    end

    always_comb begin
        nbits = 8 << in_size;
        if (nbits > LENGTH) begin
            nlast = nbits / LENGTH - 1;
        end else begin
            nlast = 0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCHUNK; i++) begin
            chunk[i] = data_q[i*LENGTH +: LENGTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready && is_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_fits  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rdy_q;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = chunk[idx_q];
                out_last  = is_last;
                out_fits  = fits_q;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        data_d = data_q;
        idx_d  = idx_q;
        last_d = last_q;
        fits_d = fits_q;
        rdy_d  = 1'b1;
        if (accept) begin
            data_d = ext;
            idx_d  = '0;
            last_d = IDXW'(nlast);
            fits_d = (ext == in_data);
        end else if (state_q == SEND && out_ready && !is_last) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            idx_q  <= '0;
            last_q <= '0;
            fits_q <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            fits_q <= fits_d;
            rdy_q  <= rdy_d;
        end
    end

endmodule

// File: tb/tb_store_narrower.sv
// Bench for store_narrower at LENGTH=16: vector table, corner sequences and
// randomized words checked against an arithmetic model of the store rules.
module tb_store_narrower;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic [1:0]  in_size = '0;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_fits;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [63:0] d;
        logic [1:0]  sz;
        logic        sg;
        logic [15:0] c [4];
        int          n;
        logic        f;
    } vec_t;

    vec_t        tbl [9];
    logic [15:0] m_c [4];
    int          m_n;
    logic        m_f;

    store_narrower #(.LENGTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_size   (in_size),
        .in_sign   (in_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_fits  (out_fits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: range check for fits, plain shifts for chunks.
    task automatic model(input logic [63:0] d, input logic [1:0] sz, input logic sg);
        int     b;
        longint sv;
        longint lim;
        logic [7:0] lowb;
        b = 8 << sz;
        m_n = (b > 16) ? b / 16 : 1;
        if (b == 64) begin
            m_f = 1'b1;
        end else if (sg) begin
            sv  = longint'(d);
            lim = longint'(1) << (b - 1);
            m_f = (sv >= -lim) && (sv < lim);
        end else begin
            m_f = ((d >> b) == 64'd0);
        end
        for (int i = 0; i < 4; i++) m_c[i] = 16'(d >> (16 * i));
        if (b == 8) begin
            lowb = d[7:0];
            m_c[0] = (sg && lowb >= 8'd128) ? {8'hFF, lowb} : {8'h00, lowb};
        end
    endtask

    task automatic run_word(input string nm, input logic [63:0] d, input logic [1:0] sz,
                            input logic sg, input logic [15:0] ec [4], input int en,
                            input logic ef, input int stall, input bit rnd, input bit hold);
        int k;
        int guard;
        int st;
        bit rd;
        st = stall;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, " ready_before_accept"}, in_ready, 1);
        in_valid  = 1'b1;
        in_data   = d;
        in_size   = sz;
        in_sign   = sg;
        out_ready = 1'b0;
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
        k = 0;
        guard = 0;
        while (k < en && guard < 100) begin
            chk({nm, " out_valid"}, out_valid, 1);
            chk({nm, " in_ready_busy"}, in_ready, 0);
            chk({nm, " out_data"}, out_data, ec[k]);
            chk({nm, " out_last"}, out_last, (k == en - 1));
            chk({nm, " out_fits"}, out_fits, ef);
            if (hold) begin
                in_data = {$urandom, $urandom};
                in_size = 2'($urandom);
                in_sign = 1'($urandom);
            end
            if (st > 0) begin
                rd = 1'b0;
                st--;
            end else begin
                rd = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            out_ready = rd;
            @(negedge clk);
            guard++;
            if (rd) k++;
        end
        chk({nm, " chunk_count"}, k, en);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({nm, " idle_out_valid"}, out_valid, 0);
        chk({nm, " idle_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic [63:0] rd_d;
        logic [1:0]  rd_sz;
        logic        rd_sg;
        logic [15:0] ca [4];

        tbl[0] = '{d: 64'h1122334455667788, sz: 2'd3, sg: 1'b0,
                   c: '{16'h7788, 16'h5566, 16'h3344, 16'h1122}, n: 4, f: 1'b1};
        tbl[1] = '{d: 64'hFFFFFFFFFFFFFFFD, sz: 2'd0, sg: 1'b1,
                   c: '{16'hFFFD, 16'h0, 16'h0, 16'h0}, n: 1, f: 1'b1};
        tbl[2] = '{d: 64'hFFFFFFFFFFFFFFFD, sz: 2'd0, sg: 1'b0,
                   c: '{16'h00FD, 16'h0, 16'h0, 16'h0}, n: 1, f: 1'b0};
        tbl[3] = '{d: 64'h00000000000000F4, sz: 2'd0, sg: 1'b0,
                   c: '{16'h00F4, 16'h0, 16'h0, 16'h0}, n: 1, f: 1'b1};
        tbl[4] = '{d: 64'h00000000000000F4, sz: 2'd0, sg: 1'b1,
                   c: '{16'hFFF4, 16'h0, 16'h0, 16'h0}, n: 1, f: 1'b0};
        tbl[5] = '{d: 64'h00000000DEADBEEF, sz: 2'd2, sg: 1'b0,
                   c: '{16'hBEEF, 16'hDEAD, 16'h0, 16'h0}, n: 2, f: 1'b1};
        tbl[6] = '{d: 64'h00000000DEADBEEF, sz: 2'd2, sg: 1'b1,
                   c: '{16'hBEEF, 16'hDEAD, 16'h0, 16'h0}, n: 2, f: 1'b0};
        tbl[7] = '{d: 64'h0000000000008000, sz: 2'd1, sg: 1'b1,
                   c: '{16'h8000, 16'h0, 16'h0, 16'h0}, n: 1, f: 1'b0};
        tbl[8] = '{d: 64'hFFFFFFFFFFFF8000, sz: 2'd1, sg: 1'b1,
                   c: '{16'h8000, 16'h0, 16'h0, 16'h0}, n: 1, f: 1'b1};

        repeat (2) @(negedge clk);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_last", out_last, 0);
        chk("rst out_fits", out_fits, 0);
        chk("rst out_data", out_data, 0);
        chk("rst in_ready", in_ready, 0);
        reset = 1'b1;
        #1;
        chk("release in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("release in_ready_high", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            ca = tbl[i].c;
            run_word($sformatf("tbl%0d", i), tbl[i].d, tbl[i].sz, tbl[i].sg,
                     ca, tbl[i].n, tbl[i].f, 0, 1'b0, 1'b0);
        end

        ca = tbl[5].c;
        run_word("stall_u", tbl[5].d, tbl[5].sz, tbl[5].sg, ca, 2, 1'b1, 3, 1'b0, 1'b0);
        ca = tbl[6].c;
        run_word("stall_s", tbl[6].d, tbl[6].sz, tbl[6].sg, ca, 2, 1'b0, 3, 1'b0, 1'b0);

        // Reset in the middle of a 64-bit word.
        in_valid = 1'b1;
        in_data  = 64'h1122334455667788;
        in_size  = 2'd3;
        in_sign  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid first_chunk", out_data, 16'h7788);
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid second_chunk", out_data, 16'h5566);
        out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid async out_valid", out_valid, 0);
        chk("mid async out_data", out_data, 0);
        chk("mid async out_last", out_last, 0);
        chk("mid async in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid rel in_ready", in_ready, 1);
        ca = '{16'h000A, 16'h0, 16'h0, 16'h0};
        run_word("after_rst", 64'hA, 2'd3, 1'b0, ca, 4, 1'b1, 0, 1'b0, 1'b0);

        // in_valid held high with junk data during SEND.
        ca = tbl[0].c;
        run_word("hold", tbl[0].d, 2'd3, 1'b0, ca, 4, 1'b1, 0, 1'b0, 1'b1);
        ca = tbl[6].c;
        run_word("hold2", tbl[6].d, 2'd2, 1'b1, ca, 2, 1'b0, 1, 1'b0, 1'b1);

        for (int r = 0; r < 40; r++) begin
            case ($urandom_range(0, 2))
                0:       rd_d = {$urandom, $urandom};
                1:       rd_d = 64'($urandom_range(0, 300));
                default: rd_d = -64'($urandom_range(1, 300));
            endcase
            rd_sz = 2'($urandom);
            rd_sg = 1'($urandom);
            model(rd_d, rd_sz, rd_sg);
            ca = m_c;
            run_word($sformatf("rnd%0d", r), rd_d, rd_sz, rd_sg, ca, m_n, m_f,
                     $urandom_range(0, 2), 1'b1, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
